// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int WB_DW = 32;  // Wishbone data width
  localparam int WB_SW = 4;   // byte-select width

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: scans the request vector starting one
// past the previous winner and wraps, returning the winner one-hot and as
// an index. o_valid is low when nothing requests.
module wb_arb_rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Walk offsets 1..N from the last winner; the first requester found wins.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int ofs = 1; ofs <= N; ofs++) begin
      int cand;
      cand = int'(i_last) + ofs;
      if (cand >= N) cand = cand - N;
      for (int k = 0; k < N; k++) begin
        if (!o_valid && i_req[k] && (k == cand)) begin
          o_valid    = 1'b1;
          o_grant[k] = 1'b1;
          o_idx      = IW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: NUM_MASTERS masters share one slave.
// A master owns the slave for its whole cyc burst; release costs one idle
// cycle before the next grant. Define WB_ARB_TIMEOUT_EN to build in a
// watchdog that ends a stalled slave cycle with err after TIMEOUT cycles.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_MASTERS-1:0]       i_m_cyc,
  input  logic [NUM_MASTERS-1:0]       i_m_stb,
  input  logic [NUM_MASTERS-1:0]       i_m_we,
  input  logic [NUM_MASTERS*AW-1:0]    i_m_adr,
  input  logic [NUM_MASTERS*WB_DW-1:0] i_m_dat,
  input  logic [NUM_MASTERS*WB_SW-1:0] i_m_sel,
  output logic [NUM_MASTERS-1:0]       o_m_ack,
  output logic [NUM_MASTERS-1:0]       o_m_err,
  output logic [WB_DW-1:0]             o_m_dat,
  output logic                         o_s_cyc,
  output logic                         o_s_stb,
  output logic                         o_s_we,
  output logic [AW-1:0]                o_s_adr,
  output logic [WB_DW-1:0]             o_s_dat,
  output logic [WB_SW-1:0]             o_s_sel,
  input  logic                         i_s_ack,
  input  logic                         i_s_err,
  input  logic [WB_DW-1:0]             i_s_dat,
  output logic [NUM_MASTERS-1:0]       o_grant
);

  localparam int IW = $clog2(NUM_MASTERS);

  arb_state_t             r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_last;

  logic [NUM_MASTERS-1:0] w_pick_grant;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_pick_valid;
  logic                   w_timeout;

  logic                   w_own_cyc;
  logic                   w_own_stb;
  logic                   w_own_we;
  logic [AW-1:0]          w_own_adr;
  logic [WB_DW-1:0]       w_own_dat;
  logic [WB_SW-1:0]       w_own_sel;

  wb_arb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .i_req   (i_m_cyc),
    .i_last  (r_last),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Select the owner's bus signals; grant is all-zero when idle, so the
  // slave side reads zero then.
  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    w_own_we  = 1'b0;
    w_own_adr = '0;
    w_own_dat = '0;
    w_own_sel = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (r_grant[k]) begin
        w_own_cyc = i_m_cyc[k];
        w_own_stb = i_m_stb[k];
        w_own_we  = i_m_we[k];
        w_own_adr = i_m_adr[k*AW +: AW];
        w_own_dat = i_m_dat[k*WB_DW +: WB_DW];
        w_own_sel = i_m_sel[k*WB_SW +: WB_SW];
      end
    end
  end

  assign o_s_cyc = w_own_cyc & ~w_timeout;
  assign o_s_stb = w_own_stb & ~w_timeout;
  assign o_s_we  = w_own_we;
  assign o_s_adr = w_own_adr;
  assign o_s_dat = w_own_dat;
  assign o_s_sel = w_own_sel;

  assign o_m_ack = r_grant & {NUM_MASTERS{i_s_ack}};
  assign o_m_err = r_grant & {NUM_MASTERS{i_s_err | w_timeout}};
  assign o_m_dat = i_s_dat;
  assign o_grant = r_grant;

  // Arbitration FSM: grant on any request when idle, hold until the owner
  // drops cyc (or the watchdog fires), then spend one cycle idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_state <= ARB_BUSY;
            r_grant <= w_pick_grant;
            r_last  <= w_pick_idx;
          end
        end
        ARB_BUSY: begin
          if (w_timeout || !w_own_cyc) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
          end
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wd_cnt;

  assign w_timeout = (r_state == ARB_BUSY) && (r_wd_cnt == CW'(TIMEOUT));

  // Count consecutive stalled strobes; held at zero while idle so each
  // burst starts from a clean count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if ((r_state != ARB_BUSY) || w_timeout || i_s_ack || i_s_err) begin
      r_wd_cnt <= '0;
    end else if (w_own_stb) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  // Without the watchdog the arbiter waits on the slave indefinitely;
  // TIMEOUT is only meaningful when the watchdog is built in.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed cycle table, hand-written
// async-reset and watchdog sequences, then randomized traffic against a
// behavioural model of the arbitration rules.
module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int TO = 8;

`ifdef WB_ARB_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    i_m_cyc, i_m_stb, i_m_we;
  logic [N*AW-1:0] i_m_adr;
  logic [N*32-1:0] i_m_dat;
  logic [N*4-1:0]  i_m_sel;
  logic [N-1:0]    o_m_ack, o_m_err;
  logic [31:0]     o_m_dat;
  logic            o_s_cyc, o_s_stb, o_s_we;
  logic [AW-1:0]   o_s_adr;
  logic [31:0]     o_s_dat;
  logic [3:0]      o_s_sel;
  logic            i_s_ack, i_s_err;
  logic [31:0]     i_s_dat;
  logic [N-1:0]    o_grant;

  logic [AW-1:0]   adr_v [N];
  logic [31:0]     dat_v [N];
  logic [3:0]      sel_v [N];

  wb_rr_arbiter #(
    .NUM_MASTERS (N),
    .AW          (AW),
    .TIMEOUT     (TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_m_cyc (i_m_cyc),
    .i_m_stb (i_m_stb),
    .i_m_we  (i_m_we),
    .i_m_adr (i_m_adr),
    .i_m_dat (i_m_dat),
    .i_m_sel (i_m_sel),
    .o_m_ack (o_m_ack),
    .o_m_err (o_m_err),
    .o_m_dat (o_m_dat),
    .o_s_cyc (o_s_cyc),
    .o_s_stb (o_s_stb),
    .o_s_we  (o_s_we),
    .o_s_adr (o_s_adr),
    .o_s_dat (o_s_dat),
    .o_s_sel (o_s_sel),
    .i_s_ack (i_s_ack),
    .i_s_err (i_s_err),
    .i_s_dat (i_s_dat),
    .o_grant (o_grant)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int k = 0; k < N; k++) begin
      i_m_adr[k*AW +: AW] = adr_v[k];
      i_m_dat[k*32 +: 32] = dat_v[k];
      i_m_sel[k*4 +: 4]   = sel_v[k];
    end
  endtask

  // Compare all outputs; slave payload is expected to come from the master
  // named by the expected grant, or be zero when none is expected.
  task automatic check_bus(input string tag, input logic [N-1:0] eg, input logic es_cyc,
                           input logic es_stb, input logic [N-1:0] eack, input logic [N-1:0] eerr);
    logic          any;
    logic          e_we;
    logic [AW-1:0] e_adr;
    logic [31:0]   e_dat;
    logic [3:0]    e_sel;
    any = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (eg[k]) begin
        any = 1'b1; e_we = i_m_we[k]; e_adr = adr_v[k]; e_dat = dat_v[k]; e_sel = sel_v[k];
      end
    end
    check($sformatf("%s grant", tag), o_grant, eg);
    check($sformatf("%s s_cyc", tag), o_s_cyc, es_cyc);
    check($sformatf("%s s_stb", tag), o_s_stb, es_stb);
    check($sformatf("%s m_ack", tag), o_m_ack, eack);
    check($sformatf("%s m_err", tag), o_m_err, eerr);
    check($sformatf("%s m_dat", tag), o_m_dat, i_s_dat);
    check($sformatf("%s s_we", tag),  o_s_we,  e_we);
    check($sformatf("%s s_adr", tag), o_s_adr, e_adr);
    check($sformatf("%s s_dat", tag), o_s_dat, e_dat);
    check($sformatf("%s s_sel", tag), o_s_sel, e_sel);
    if (!any) check($sformatf("%s idle s_adr", tag), o_s_adr, 0);
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] cyc;
    logic         s_ack;
    logic         s_err;
    logic [N-1:0] e_grant;
    logic         e_s_cyc;
    logic [N-1:0] e_ack;
    logic [N-1:0] e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [N-1:0] cyc, input logic ack, input logic err,
                     input logic [N-1:0] eg, input logic ec, input logic [N-1:0] ea, input logic [N-1:0] ee);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.s_ack = ack; v.s_err = err;
    v.e_grant = eg; v.e_s_cyc = ec; v.e_ack = ea; v.e_err = ee;
    tbl.push_back(v);
  endtask

  // Behavioural model state for the random phase.
  logic         mdl_busy;
  int           mdl_own, mdl_last, mdl_cnt;
  logic         mdl_to;
  logic [N-1:0] eg, eack, eerr;
  logic         es_cyc, es_stb;

  initial begin
    // Reset with all masters requesting and slave ack/err high: nothing leaks.
    reset = 1'b1;
    i_m_cyc = '1; i_m_stb = '1; i_s_ack = 1'b1; i_s_err = 1'b1; i_s_dat = 32'hDEADBEEF;
    for (int k = 0; k < N; k++) begin
      adr_v[k] = 32'h1000_0000 + 32'h100 * 32'(k);
      dat_v[k] = 32'hA000_0000 | 32'(k + 1);
      sel_v[k] = 4'(1 << k);
      i_m_we[k] = (k % 2) == 1;
    end
    pack();
    #3;
    check_bus("reset", 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);

    //  rst cyc     ack err  grant   s_cyc ack     err
    add(0, 3'b000, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add(0, 3'b000, 1, 0, 3'b000, 0, 3'b000, 3'b000);
    add(0, 3'b010, 0, 0, 3'b000, 0, 3'b000, 3'b000);  // m1 requests
    add(0, 3'b010, 0, 0, 3'b010, 1, 3'b000, 3'b000);  // granted next edge
    add(0, 3'b010, 1, 0, 3'b010, 1, 3'b010, 3'b000);  // ack to m1 only
    add(0, 3'b000, 0, 0, 3'b010, 0, 3'b000, 3'b000);
    add(0, 3'b000, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add(1, 3'b111, 1, 1, 3'b000, 0, 3'b000, 3'b000);  // reset again
    add(0, 3'b111, 0, 0, 3'b000, 0, 3'b000, 3'b000);  // all request
    add(0, 3'b111, 1, 0, 3'b001, 1, 3'b001, 3'b000);  // m0 first
    add(0, 3'b110, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add(0, 3'b110, 0, 0, 3'b000, 0, 3'b000, 3'b000);  // dead cycle
    add(0, 3'b110, 1, 0, 3'b010, 1, 3'b010, 3'b000);  // m1
    add(0, 3'b100, 0, 0, 3'b010, 0, 3'b000, 3'b000);
    add(0, 3'b100, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add(0, 3'b101, 1, 0, 3'b100, 1, 3'b100, 3'b000);  // m2
    add(0, 3'b001, 0, 0, 3'b100, 0, 3'b000, 3'b000);
    add(0, 3'b001, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add(0, 3'b001, 1, 0, 3'b001, 1, 3'b001, 3'b000);  // m0 again
    add(0, 3'b000, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add(0, 3'b000, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add(0, 3'b001, 0, 0, 3'b000, 0, 3'b000, 3'b000);  // bus lock: m0 alone
    add(0, 3'b101, 1, 0, 3'b001, 1, 3'b001, 3'b000);  // beat 1, m2 waits
    add(0, 3'b101, 1, 0, 3'b001, 1, 3'b001, 3'b000);
    add(0, 3'b101, 1, 0, 3'b001, 1, 3'b001, 3'b000);
    add(0, 3'b101, 1, 0, 3'b001, 1, 3'b001, 3'b000);  // beat 4
    add(0, 3'b100, 0, 0, 3'b001, 0, 3'b000, 3'b000);  // m0 drops cyc
    add(0, 3'b100, 1, 0, 3'b000, 0, 3'b000, 3'b000);  // idle: no ack to m2
    add(0, 3'b100, 0, 0, 3'b100, 1, 3'b000, 3'b000);  // m2 two edges later
    add(0, 3'b000, 0, 0, 3'b100, 0, 3'b000, 3'b000);
    add(0, 3'b010, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add(0, 3'b010, 0, 1, 3'b010, 1, 3'b000, 3'b010);  // err to m1
    add(0, 3'b010, 0, 0, 3'b010, 1, 3'b000, 3'b000);  // grant retained
    add(0, 3'b010, 1, 0, 3'b010, 1, 3'b010, 3'b000);
    add(0, 3'b000, 0, 0, 3'b010, 0, 3'b000, 3'b000);
    add(0, 3'b000, 0, 0, 3'b000, 0, 3'b000, 3'b000);

    foreach (tbl[r]) begin
      tick();
      reset   = tbl[r].rst;
      i_m_cyc = tbl[r].cyc;
      i_m_stb = tbl[r].cyc;
      i_s_ack = tbl[r].s_ack;
      i_s_err = tbl[r].s_err;
      i_s_dat = (r == 4) ? 32'hDEADBEEF : $urandom;
      #3;
      check_bus($sformatf("row%0d", r), tbl[r].e_grant, tbl[r].e_s_cyc, tbl[r].e_s_cyc,
                tbl[r].e_ack, tbl[r].e_err);
    end

    // Async reset mid-burst: outputs drop between edges, then m0 wins first.
    tick();
    i_m_cyc = 3'b001; i_m_stb = 3'b001; i_s_ack = 1'b0; i_s_err = 1'b0;
    tick();
    #3;
    check("pre-reset grant", o_grant, 3'b001);
    check("pre-reset s_cyc", o_s_cyc, 1'b1);
    reset = 1'b1;
    #1;
    check("async grant", o_grant, 3'b000);
    check("async s_cyc", o_s_cyc, 1'b0);
    check("async s_stb", o_s_stb, 1'b0);
    check("async s_adr", o_s_adr, 0);
    check("async s_sel", o_s_sel, 0);
    tick();
    reset = 1'b0; i_m_cyc = 3'b111; i_m_stb = 3'b111;
    tick();
    #3;
    check("post-reset first grant", o_grant, 3'b001);

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog: m0 stalls forever, m1 pending.
    reset = 1'b1; i_m_cyc = '0; i_m_stb = '0;
    tick();
    reset = 1'b0;
    tick();
    i_m_cyc = 3'b011; i_m_stb = 3'b011; i_s_ack = 1'b0; i_s_err = 1'b0;
    #3;
    check("wd idle grant", o_grant, 3'b000);
    for (int j = 1; j <= TO + 1; j++) begin
      tick();
      #3;
      check($sformatf("wd c%0d grant", j), o_grant, 3'b001);
      check($sformatf("wd c%0d err", j), o_m_err, (j == TO + 1) ? 3'b001 : 3'b000);
      check($sformatf("wd c%0d s_stb", j), o_s_stb, (j == TO + 1) ? 1'b0 : 1'b1);
      check($sformatf("wd c%0d s_cyc", j), o_s_cyc, (j == TO + 1) ? 1'b0 : 1'b1);
    end
    tick();
    #3;
    check("wd released", o_grant, 3'b000);
    tick();
    #3;
    check("wd next grant", o_grant, 3'b010);
`endif

    // Randomized traffic against the behavioural model.
    reset = 1'b1; i_m_cyc = '0; i_m_stb = '0;
    tick();
    reset = 1'b0;
    mdl_busy = 1'b0; mdl_own = 0; mdl_last = N - 1; mdl_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (mdl_busy && mdl_own == k) i_m_cyc[k] = ($urandom_range(7) != 0);
        else                          i_m_cyc[k] = ($urandom_range(2) == 0);
        i_m_stb[k] = i_m_cyc[k] && ($urandom_range(3) != 0);
        i_m_we[k]  = 1'($urandom_range(1));
        adr_v[k]   = $urandom;
        dat_v[k]   = $urandom;
        sel_v[k]   = 4'($urandom_range(15));
      end
      pack();
      i_s_ack = ($urandom_range(3) == 0);
      i_s_err = ($urandom_range(15) == 0);
      i_s_dat = $urandom;
      #3;
      mdl_to = WD && mdl_busy && (mdl_cnt == TO);
      eg = '0; eack = '0; eerr = '0; es_cyc = 1'b0; es_stb = 1'b0;
      if (mdl_busy) begin
        eg[mdl_own] = 1'b1;
        es_cyc = i_m_cyc[mdl_own] && !mdl_to;
        es_stb = i_m_stb[mdl_own] && !mdl_to;
        if (i_s_ack) eack[mdl_own] = 1'b1;
        if (i_s_err || mdl_to) eerr[mdl_own] = 1'b1;
      end
      check_bus($sformatf("rand%0d", c), eg, es_cyc, es_stb, eack, eerr);
      // Advance the model across the coming edge.
      if (!mdl_busy) begin
        for (int ofs = 1; ofs <= N; ofs++) begin
          int cand;
          cand = (mdl_last + ofs) % N;
          if (!mdl_busy && i_m_cyc[cand]) begin
            mdl_busy = 1'b1; mdl_own = cand; mdl_last = cand; mdl_cnt = 0;
          end
        end
      end else if (mdl_to || !i_m_cyc[mdl_own]) begin
        mdl_busy = 1'b0; mdl_cnt = 0;
      end else if (i_s_ack || i_s_err) begin
        mdl_cnt = 0;
      end else if (i_m_stb[mdl_own]) begin
        mdl_cnt++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone classic arbiter that shares one slave port between `NUM_MASTERS` masters. Its first use is putting VexRiscv iBus, dBus and a future DMA/debug master in front of the single `servant_ram` port. It sits between the masters and `wb_intercon` or the RAM. Ownership is held for the whole `cyc` burst, and an optional watchdog terminates hung slave cycles with `err`.

## Interface
Parameters:
- `NUM_MASTERS`, 3: number of requesting masters (2..8).
- `AW`, 32: address width.
- `TIMEOUT`, 255: watchdog limit in cycles; only used when the watchdog is compiled in.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `i_m_cyc`  in  NUM_MASTERS  per-master `cyc`.
- `i_m_stb`  in  NUM_MASTERS  per-master `stb`.
- `i_m_we`  in  NUM_MASTERS  per-master write enable.
- `i_m_adr`  in  NUM_MASTERS*AW  packed addresses; master k occupies bits [k*AW +: AW].
- `i_m_dat`  in  NUM_MASTERS*32  packed write data.
- `i_m_sel`  in  NUM_MASTERS*4  packed byte selects.
- `o_m_ack`  out  NUM_MASTERS  per-master `ack`.
- `o_m_err`  out  NUM_MASTERS  per-master `err`.
- `o_m_dat`  out  32  read data, broadcast to all masters.
- `o_s_cyc`, `o_s_stb`, `o_s_we`  out  1 each  slave control.
- `o_s_adr`  out  AW  slave address.
- `o_s_dat`  out  32  slave write data.
- `o_s_sel`  out  4  slave byte selects.
- `i_s_ack`  in  1  slave `ack`.
- `i_s_err`  in  1  slave `err`.
- `i_s_dat`  in  32  slave read data.
- `o_grant`  out  NUM_MASTERS  one-hot owner; all zero when idle.

## Operation
- **State machine.** Two states, IDLE and BUSY.
- **IDLE.**
  - If any `i_m_cyc` is high, the winner is registered into `grant` and `last` on the clock edge, and the state moves to BUSY.
  - With no request the block stays in IDLE.
- **Round-robin order.**
  - Search starts at index `last+1` and wraps modulo `NUM_MASTERS`.
  - `last` resets to `NUM_MASTERS-1`, so master 0 wins the first arbitration.
- **BUSY.**
  - Slave outputs are muxed combinationally from the owner's signals: `o_s_cyc = i_m_cyc[own]`, `o_s_stb = i_m_stb[own]`, and likewise for `we`, `adr`, `dat`, `sel`.
  - `o_m_ack[own] = i_s_ack` and `o_m_err[own] = i_s_err`. Every other master sees 0.
  - `o_m_dat = i_s_dat` unconditionally.
- **Release.**
  - When the owner drops `cyc`, the next edge returns the block to IDLE and clears `grant`.
  - There is exactly one dead cycle before the next grant.
- **Bus lock.** The owner keeps the bus for as many `stb`/`ack` beats as it holds `cyc`. No preemption.
- **Slave `err`.** Passed through to the owner only; the grant is unaffected.
- **Reset mid-transaction.** All outputs drop immediately (asynchronously); the in-flight cycle is abandoned.

## Timing
- **Reset values.**
  - `grant` = 0, state = IDLE, `last` = NUM_MASTERS-1.
  - All `o_s_*` = 0, all `o_m_ack`/`o_m_err` = 0, `o_grant` = 0.
  - `o_m_dat` follows `i_s_dat`.
- **Grant latency.** A `cyc` raised in cycle N (block idle) is granted at edge N+1. The slave sees `cyc`/`stb` from cycle N+1.
- **Ack path.** Combinational, zero added latency.
- **Rearbitration.** Owner `cyc` low in cycle N means IDLE in N+1 and a new grant at edge N+2.
- **Simultaneous requests in IDLE.** Round-robin order decides. A master requesting continuously waits at most NUM_MASTERS-1 bursts.

## Configuration
- **`WB_ARB_TIMEOUT_EN` defined:**
  - A counter of width `$clog2(TIMEOUT+1)` increments each BUSY cycle with `o_s_stb` high and neither `i_s_ack` nor `i_s_err` high.
  - The counter clears on `ack`/`err`, on entering BUSY, and on reset.
  - In the cycle the counter equals `TIMEOUT`:
    - `o_m_err[own]` is forced to 1 for that one cycle.
    - `o_s_cyc` and `o_s_stb` are forced to 0.
    - The next state is IDLE, regardless of the owner's `cyc`.
- **Undefined:** no counter, and the block waits indefinitely for the slave.

## Structure
- **Package `wb_arb_pkg`:**
  - State enum `arb_state_t` {ARB_IDLE, ARB_BUSY}.
  - Constant `WB_DW` = 32.
  - Constant `WB_SW` = 4.
- **Sub-module `wb_arb_rr_pick`:** combinational round-robin picker. Inputs are the request vector and `last`; outputs are the one-hot winner and its index. It is reused by the later interrupt and DMA schedulers.

## Test plan
- **Reset then single request.** Master 1 `cyc`/`stb` in cycle 3 → `o_grant` = 3'b010 at edge 4 → slave `ack` in cycle 5 → `o_m_ack` = 3'b010 and `o_m_dat` equals `i_s_dat` (0xDEADBEEF).
- **Simultaneous requests from reset.** All three masters request in the same cycle → grant order 0, 1, 2, 0 over four 1-beat bursts, with one idle cycle between grants.
- **Bus lock.** Master 0 holds `cyc` for 4 beats while master 2 requests → master 2 is granted exactly 2 cycles after master 0 drops `cyc`. Master 2 never sees `ack` before then.
- **Error passthrough.** `i_s_err` = 1 during master 1's cycle → `o_m_err` = 3'b010 and the grant is retained while master 1 keeps `cyc`.
- **Watchdog (`WB_ARB_TIMEOUT_EN`, `TIMEOUT` = 8).** Slave never acks → `o_m_err[own]` pulses one cycle when the counter reaches 8 (9th stalled cycle) → IDLE next cycle → a pending master is granted on the following edge.
- **Async reset mid-burst.** Assert `reset` between clock edges while BUSY → all `o_s_*` and `o_grant` are 0 without waiting for a clock edge. After deassertion, master 0 has first priority.
